bulb_pwm_driver: RTL and testbench
==================================

# bulb_pwm_driver

Downstream consumer of the light-bulb step sequencer. It takes the sequencer's 3-bit thermometer level (000/001/011/111) and drives the physical bulb output with a glitch-free PWM waveform. Brightness ramps smoothly, one quarter-duty step at a time, toward the commanded level. Illegal thermometer codes are flagged and ignored.

## Interface
Parameters:
- PERIOD, 16: PWM period in clk cycles; multiple of 4, at least 4. Q = PERIOD/4 is the number of cycles per quarter-duty.
- RAMP_PERIODS, 4: number of whole PWM periods between consecutive duty steps; at least 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- level  in  3  thermometer brightness command from the sequencer, sampled every cycle.
- pwm_out  out  1  registered bulb drive.
- duty  out  3  current duty in quarters, 0..4.
- at_target  out  1  duty == target; combinational from registers.
- code_err  out  1  registered one-cycle pulse on an illegal level code.

Reset is synchronous, active-high, named reset; the clock is clk.

## Operation
- Decode of level to target quarters:
  - 000 -> 0, 001 -> 1, 011 -> 2, 111 -> 4.
  - Any other code leaves target unchanged and sets code_err=1 for one cycle.
  - target register is updated one cycle after level is sampled.
- Period counter cnt runs 0..PERIOD-1 and wraps. period_tick is high when cnt == PERIOD-1.
- Ramp counter rc:
  - While duty != target, rc increments on each period_tick.
  - On a period_tick with rc == RAMP_PERIODS-1: duty moves one step toward target (+1 or -1) and rc returns to 0.
  - While duty == target, rc is held at 0.
- Step direction is re-evaluated at every step, so a target change mid-ramp reverses or extends the ramp without clearing rc.
- Duty changes only at the period boundary, so no period ever mixes two duties.
- pwm_out <= (cnt < duty*Q).
  - duty=0 gives pwm_out constantly 0.
  - duty=4 gives pwm_out constantly 1, with no gap at the wrap.
- Arithmetic: duty*Q is computed at width clog2(PERIOD)+1. duty is saturated to 0..4, and no value outside that range is ever reachable.

## Timing
- Reset values (cycle after reset is sampled high): cnt=0, rc=0, target=0, duty=0, pwm_out=0, code_err=0, at_target=1.
- Reset mid-operation aborts the ramp immediately. There is no residual pulse, and cnt restarts at 0.
- Latency from level to target: 1 cycle.
- Latency from level to code_err: 1 cycle.
- pwm_out lags cnt/duty by 1 cycle.
- Latency from level change to first duty step: between RAMP_PERIODS-1 and RAMP_PERIODS full periods plus 1 cycle, depending on the cnt phase and the rc value.
- Full ramp 0 -> 4: 4*RAMP_PERIODS periods, nominally.
- Level changing on the same cycle as a period_tick: the step uses the old target, and the new target applies from the next step.
- Illegal code on consecutive cycles: code_err stays high for each such cycle.

## Structure
- Shared package bulb_pkg holds:
  - Level code localparams LVL_OFF=3'b000, LVL_1=3'b001, LVL_2=3'b011, LVL_FULL=3'b111.
  - DUTY_MAX=4.
  - Function lvl_to_quarters returning {valid, quarters[2:0]}.
- Sub-module bulb_pwm_counter (parameter PERIOD): outputs cnt and period_tick, with synchronous reset. It is reused by later bulb output stages.
- The top level holds the decode, target, rc, duty and pwm_out registers.

## Test plan
All scenarios use PERIOD=16 (Q=4) and RAMP_PERIODS=2.
- Reset: hold reset 3 cycles with level=111 -> pwm_out=0, duty=0, at_target=1, code_err=0 throughout. After release, duty stays 0 until the first step boundary.
- Level 000 -> 001 from reset -> target=1 next cycle, at_target drops. duty becomes 1 at the 2nd period_tick. Afterwards pwm_out is high exactly cycles cnt 0..3 of every 16, and at_target=1.
- Level 111 from duty 0 -> duty 1, 2, 3, 4 at 32-cycle intervals. At duty 4, pwm_out is high continuously for at least 48 cycles across wraps, and at_target=1.
- Level 101 while target=2 and duty=2 -> code_err=1 for exactly 1 cycle. target, duty and pwm_out pattern (8 of 16 high) are unchanged.
- Ramp reversal: ramping 0 -> 4, drive level=000 when duty=2 -> next steps are duty 1 then 0, at 32-cycle spacing, never reaching 3.
- Reset mid-ramp at duty=3 -> next cycle pwm_out=0, duty=0, cnt=0. The ramp restarts from 0 after release.

Source files
------------

// File: rtl/bulb_pkg.sv
// Shared definitions for the bulb output stages: thermometer level codes,
// duty limits and the level-to-quarters decoder.
package bulb_pkg;

    localparam logic [2:0] LVL_OFF  = 3'b000;
    localparam logic [2:0] LVL_1    = 3'b001;
    localparam logic [2:0] LVL_2    = 3'b011;
    localparam logic [2:0] LVL_FULL = 3'b111;

    localparam int DUTY_MAX = 4;

    typedef struct packed {
        logic       valid;
        logic [2:0] quarters;
    } lvl_dec_t;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_dir_t;

    // Illegal codes return valid=0; quarters is then don't-care (driven 0).
    function automatic lvl_dec_t lvl_to_quarters(input logic [2:0] lvl);
        lvl_dec_t r_dec;
        r_dec = '{valid: 1'b1, quarters: 3'd0};
        case (lvl)
            LVL_OFF:  r_dec.quarters = 3'd0;
            LVL_1:    r_dec.quarters = 3'd1;
            LVL_2:    r_dec.quarters = 3'd2;
            LVL_FULL: r_dec.quarters = 3'(DUTY_MAX);
            default:  r_dec.valid    = 1'b0;
        endcase
        return r_dec;
    endfunction

endpackage

// File: rtl/bulb_pwm_counter.sv
// Free-running PWM period counter 0..PERIOD-1 with a tick on the last count.
// Shared by the bulb output stages so every stage sees the same period phase.
module bulb_pwm_counter #(
    parameter int PERIOD = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [$clog2(PERIOD)-1:0] o_cnt,
    output logic                      o_period_tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt         = r_cnt;
    assign o_period_tick = (r_cnt == LAST);

endmodule

// File: rtl/bulb_pwm_driver.sv
// Bulb PWM driver: decodes the sequencer's thermometer level into a target duty
// and ramps the PWM duty toward it one quarter per RAMP_PERIODS whole periods.
module bulb_pwm_driver
    import bulb_pkg::*;
#(
    parameter int PERIOD       = 16,
    parameter int RAMP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] level,
    output logic       pwm_out,
    output logic [2:0] duty,
    output logic       at_target,
    output logic       code_err
);

    localparam int CW = $clog2(PERIOD);
    localparam int MW = CW + 1;
    localparam int Q  = PERIOD / 4;
    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    localparam logic [RW-1:0] RC_LAST  = RW'(RAMP_PERIODS - 1);
    localparam logic [2:0]    DUTY_TOP = 3'(DUTY_MAX);
    localparam logic [MW-1:0] Q_M      = MW'(Q);

    logic [CW-1:0] w_cnt;
    logic          w_period_tick;
    lvl_dec_t      w_dec;
    step_dir_t     w_dir;
    logic [RW-1:0] w_rc_next;
    logic [2:0]    w_duty_next;
    logic [MW-1:0] w_thresh;
    logic          w_pwm_next;

    logic [2:0]    r_target;
    logic [2:0]    r_duty;
    logic [RW-1:0] r_rc;
    logic          r_pwm;
    logic          r_code_err;

    bulb_pwm_counter #(
        .PERIOD (PERIOD)
    ) u_counter (
        .clk           (clk),
        .reset         (reset),
        .o_cnt         (w_cnt),
        .o_period_tick (w_period_tick)
    );

    assign w_dec = lvl_to_quarters(level);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_target   <= 3'd0;
            r_code_err <= 1'b0;
        end else begin
            if (w_dec.valid) begin
                r_target <= w_dec.quarters;
            end
            r_code_err <= ~w_dec.valid;
        end
    end

    // Direction is recomputed from the live target, so a mid-ramp target
    // change reverses or extends the ramp while rc keeps its progress.
    always_comb begin
        w_dir = STEP_HOLD;
        if (r_duty < r_target && r_duty < DUTY_TOP) begin
            w_dir = STEP_UP;
        end else if (r_duty > r_target && r_duty != 3'd0) begin
            w_dir = STEP_DOWN;
        end
    end

    always_comb begin
        w_rc_next   = r_rc;
        w_duty_next = r_duty;
        if (r_duty == r_target) begin
            w_rc_next = '0;
        end else if (w_period_tick) begin
            if (r_rc == RC_LAST) begin
                w_rc_next = '0;
                case (w_dir)
                    STEP_UP:   w_duty_next = r_duty + 3'd1;
                    STEP_DOWN: w_duty_next = r_duty - 3'd1;
                    default:   w_duty_next = r_duty;
                endcase
            end else begin
                w_rc_next = r_rc + 1'b1;
            end
        end
    end

    // duty only moves on the last cycle of a period, so each period is
    // drawn with a single duty value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rc   <= '0;
            r_duty <= 3'd0;
        end else begin
            r_rc   <= w_rc_next;
            r_duty <= w_duty_next;
        end
    end

    assign w_thresh   = MW'(r_duty) * Q_M;
    assign w_pwm_next = ({1'b0, w_cnt} < w_thresh);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_pwm_next;
        end
    end

    assign pwm_out   = r_pwm;
    assign duty      = r_duty;
    assign at_target = (r_duty == r_target);
    assign code_err  = r_code_err;

endmodule

// File: tb/tb_bulb_pwm_driver.sv
// Scoreboard bench for bulb_pwm_driver (PERIOD=16, RAMP_PERIODS=2): expected
// duty steps and code_err pulses are queued with their cycle; a monitor pops them.
module tb_bulb_pwm_driver;

    localparam int EV_DUTY = 0;
    localparam int EV_ERR  = 1;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] level = 3'b111;
    logic       pwm_out;
    logic [2:0] duty;
    logic       at_target;
    logic       code_err;

    int   cyc = 0;
    int   base = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;
    logic [2:0] prev_duty = 3'd0;
    ev_t  exp_q[$];

    bulb_pwm_driver #(
        .PERIOD       (16),
        .RAMP_PERIODS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .level     (level),
        .pwm_out   (pwm_out),
        .duty      (duty),
        .at_target (at_target),
        .code_err  (code_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (r=%0d)", name, act, exp, cyc - base);
        end else begin
            $display("ok   %s = %0d (r=%0d)", name, act, cyc - base);
        end
    endtask

    task automatic push(input int kind, input int rel, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = base + rel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic handle_event(input int kind, input int val);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d at cyc=%0d, expected none",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end else begin
                $display("ok   event kind=%0d val=%0d cyc=%0d", kind, val, cyc);
            end
        end
    endtask

    // Monitor: every duty change and every code_err cycle is a DUT output event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (duty !== prev_duty) handle_event(EV_DUTY, int'(duty));
            if (code_err === 1'b1)  handle_event(EV_ERR, 1);
        end
        prev_duty <= duty;
    end

    // Wait until k posedges after the last reset release, then sit at the negedge.
    task automatic wait_rel(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic do_reset(input int n, input int prev, input logic [2:0] lv_in,
                            input logic [2:0] lv_after);
        reset = 1'b1;
        level = lv_in;
        if (mon_en && prev != 0) begin
            ev_t e;
            e.kind = EV_DUTY;
            e.cyc  = cyc + 1;
            e.val  = 0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_pwm_out", int'(pwm_out), 0);
            check("rst_duty", int'(duty), 0);
            check("rst_at_target", int'(at_target), 1);
            check("rst_code_err", int'(code_err), 0);
        end
        reset  = 1'b0;
        level  = lv_after;
        base   = cyc;
        mon_en = 1'b1;
    endtask

    // Sample len cycles from relative cycle start_r; pwm must be high for the
    // first nhigh cycles of each 16-cycle window.
    task automatic check_pwm(input string name, input int start_r, input int nhigh,
                             input int len);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < len; i++) begin
            wait_rel(start_r + i);
            if (int'(pwm_out) != (((i % 16) < nhigh) ? 1 : 0)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (bad != 0)
            $display("pwm window %s: first wrong sample at offset %0d", name, first_bad);
        check(name, bad, 0);
    endtask

    initial begin
        // Reset with level 111 held, then 000->001: step to duty 1 on the 2nd tick.
        do_reset(3, 0, 3'b111, 3'b001);
        push(EV_DUTY, 32, 1);
        wait_rel(1);
        check("s1_at_target_drop", int'(at_target), 0);
        wait_rel(31);
        check("s1_duty_before_step", int'(duty), 0);
        check_pwm("s1_pwm_duty1", 33, 4, 16);
        wait_rel(49);
        check("s1_at_target", int'(at_target), 1);

        // Full ramp 0 -> 4 at 32-cycle spacing, then continuous high across wraps.
        do_reset(2, 1, 3'b111, 3'b111);
        push(EV_DUTY, 32, 1);
        push(EV_DUTY, 64, 2);
        push(EV_DUTY, 96, 3);
        push(EV_DUTY, 128, 4);
        check_pwm("s2_pwm_duty4", 129, 16, 48);
        wait_rel(177);
        check("s2_at_target", int'(at_target), 1);
        check("s2_duty", int'(duty), 4);

        // Illegal codes at duty 2: single pulse, then a two-cycle run.
        do_reset(2, 4, 3'b111, 3'b011);
        push(EV_DUTY, 32, 1);
        push(EV_DUTY, 64, 2);
        push(EV_ERR, 71, 1);
        push(EV_ERR, 101, 1);
        push(EV_ERR, 102, 1);
        wait_rel(70);
        level = 3'b101;
        wait_rel(71);
        level = 3'b011;
        wait_rel(72);
        check("s4_duty_kept", int'(duty), 2);
        check("s4_at_target", int'(at_target), 1);
        check("s4_code_err_cleared", int'(code_err), 0);
        check_pwm("s4_pwm_duty2", 81, 8, 16);
        wait_rel(100);
        level = 3'b010;
        wait_rel(102);
        level = 3'b011;
        wait_rel(104);
        check("s4_duty_after_run", int'(duty), 2);

        // Reversal: level 000 once duty reaches 2 -> 1 then 0, never 3.
        do_reset(2, 2, 3'b111, 3'b111);
        push(EV_DUTY, 32, 1);
        push(EV_DUTY, 64, 2);
        push(EV_DUTY, 96, 1);
        push(EV_DUTY, 128, 0);
        wait_rel(65);
        level = 3'b000;
        wait_rel(170);
        check("s5_duty_final", int'(duty), 0);
        check("s5_at_target", int'(at_target), 1);

        // Reset mid-ramp at duty 3; ramp restarts with the same step timing.
        do_reset(2, 0, 3'b111, 3'b111);
        push(EV_DUTY, 32, 1);
        push(EV_DUTY, 64, 2);
        push(EV_DUTY, 96, 3);
        wait_rel(100);
        check("s6_duty_before_reset", int'(duty), 3);
        do_reset(2, 3, 3'b111, 3'b111);
        push(EV_DUTY, 32, 1);
        wait_rel(31);
        check("s6_pwm_low_before_step", int'(pwm_out), 0);
        wait_rel(40);
        check("s6_duty_restart", int'(duty), 1);

        check("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
